piso_serializer: RTL and testbench

PISO_SERIALIZER -- requirements
Module: piso_serializer

---
 rtl/piso_serializer_pkg.sv | 12 +
 rtl/piso_serializer.sv | 106 ++++++++++
 tb/tb_piso_serializer.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the parallel-in/serial-out serializer:
// FSM state encoding and the default word width.
package piso_serializer_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer with a valid/ready load port and a
// shift_en-paced serial output that supports back-to-back words.
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] din,
  input  logic             shift_en,
  output logic             sout,
  output logic             sout_valid,
  output logic             last,
  output logic             busy
);

  localparam int             CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  CNT_ZERO = CW'(0);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  state_e             state_r;
  state_e             state_s;
  logic [CW-1:0]      cnt_r;
  logic [CW-1:0]      cnt_s;
  logic [WIDTH-1:0]   shreg_r;
  logic [WIDTH-1:0]   shreg_s;
  logic               handshake_s;
  logic               busy_s;
  logic               last_s;
  logic               sout_s;
  logic [CW-1:0]      bit_idx_s;

  // The final bit being consumed frees the block for a new word in the same cycle.
  assign load_ready  = (state_r == IDLE) | (last & shift_en);
  assign handshake_s = load_valid & load_ready;

  // Next-state, next-counter, next-data and the output values they imply.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    shreg_s   = shreg_r;
    if (handshake_s) begin
      state_s = SHIFT;
      cnt_s   = CNT_ZERO;
      shreg_s = din;
    end else begin
      case (state_r)
        SHIFT: begin
          if (shift_en) begin
            if (cnt_r == CNT_LAST) begin
              state_s = IDLE;
              cnt_s   = CNT_ZERO;
            end else begin
              cnt_s = cnt_r + CNT_ONE;
            end
          end else begin
            cnt_s = cnt_r;
          end
        end
        IDLE: begin
          state_s = IDLE;
        end
        default: begin
          state_s = IDLE;
          cnt_s   = CNT_ZERO;
        end
      endcase
    end

    busy_s    = (state_s == SHIFT);
    last_s    = busy_s & (cnt_s == CNT_LAST);
    bit_idx_s = MSB_FIRST ? (CNT_LAST - cnt_s) : cnt_s;
    if (busy_s) begin
      sout_s = shreg_s[bit_idx_s];
    end else begin
      sout_s = 1'b0;
    end
  end

  // State, datapath and registered outputs; reset dominates any handshake or shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= CNT_ZERO;
      shreg_r    <= {WIDTH{1'b0}};
      sout       <= 1'b0;
      sout_valid <= 1'b0;
      last       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      shreg_r    <= shreg_s;
      sout       <= sout_s;
      sout_valid <= busy_s;
      last       <= last_s;
      busy       <= busy_s;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: a bit-level scoreboard fed at each load
// handshake and drained as bits are consumed, plus per-scenario pulse counts.
module tb_piso_serializer;

  logic       clk;
  logic       rst;
  logic       load_valid0, load_ready0, shift_en0, sout0, sout_valid0, last0, busy0;
  logic [7:0] din0;
  logic       load_valid1, load_ready1, shift_en1, sout1, sout_valid1, last1, busy1;
  logic [7:0] din1;

  int checks   = 0;
  int failures = 0;
  int vcnt, lcnt, bcnt;
  bit armed = 1'b0;
  bit q0[$];
  bit q1[$];

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst(rst), .load_valid(load_valid0), .load_ready(load_ready0),
    .din(din0), .shift_en(shift_en0), .sout(sout0), .sout_valid(sout_valid0),
    .last(last0), .busy(busy0)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .load_valid(load_valid1), .load_ready(load_ready1),
    .din(din1), .shift_en(shift_en1), .sout(sout1), .sout_valid(sout_valid1),
    .last(last1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: predict handshakes from the model, advance it, then check both DUTs.
  task automatic tick();
    bit       rdy0, rdy1, adv0, adv1, hs0, hs1;
    bit [7:0] d0, d1;
    rdy0 = (q0.size() == 0) || (q0.size() == 1 && shift_en0);
    rdy1 = (q1.size() == 0) || (q1.size() == 1 && shift_en1);
    if (armed && !rst) begin
      chk("load_ready0", load_ready0, rdy0);
      chk("load_ready1", load_ready1, rdy1);
    end
    adv0 = (q0.size() > 0) && shift_en0;
    adv1 = (q1.size() > 0) && shift_en1;
    hs0  = load_valid0 && rdy0;
    hs1  = load_valid1 && rdy1;
    d0   = din0;
    d1   = din1;
    @(posedge clk);
    #1;
    armed = 1'b1;
    if (rst) begin
      q0.delete();
      q1.delete();
    end else begin
      if (adv0) void'(q0.pop_front());
      if (adv1) void'(q1.pop_front());
      if (hs0) for (int i = 7; i >= 0; i--) q0.push_back(d0[i]);
      if (hs1) for (int i = 0; i <= 7; i++) q1.push_back(d1[i]);
    end
    chk("sout_valid0", sout_valid0, q0.size() > 0);
    chk("busy0", busy0, q0.size() > 0);
    chk("last0", last0, q0.size() == 1);
    chk("sout0", sout0, (q0.size() > 0) ? q0[0] : 1'b0);
    chk("sout_valid1", sout_valid1, q1.size() > 0);
    chk("busy1", busy1, q1.size() > 0);
    chk("last1", last1, q1.size() == 1);
    chk("sout1", sout1, (q1.size() > 0) ? q1[0] : 1'b0);
    if (sout_valid0) vcnt++;
    if (last0) lcnt++;
    if (busy0) bcnt++;
  endtask

  task automatic clear_stats();
    vcnt = 0;
    lcnt = 0;
    bcnt = 0;
  endtask

  initial begin
    rst = 1'b1;
    load_valid0 = 1'b0; din0 = 8'h00; shift_en0 = 1'b0;
    load_valid1 = 1'b0; din1 = 8'h00; shift_en1 = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Single MSB-first word, shift_en held high
    clear_stats();
    shift_en0 = 1'b1; load_valid0 = 1'b1; din0 = 8'hA5;
    tick();
    load_valid0 = 1'b0; din0 = 8'h00;
    for (int i = 0; i < 8; i++) tick();
    chk_int("a5_valid_cycles", vcnt, 8);
    chk_int("a5_last_pulses", lcnt, 1);
    chk("a5_idle_after", busy0, 1'b0);

    // Back-to-back words with load_valid held across the boundary
    clear_stats();
    load_valid0 = 1'b1; din0 = 8'hFF;
    tick();
    din0 = 8'h00;
    for (int i = 0; i < 8; i++) tick();
    load_valid0 = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    chk_int("b2b_valid_cycles", vcnt, 16);
    chk_int("b2b_last_pulses", lcnt, 2);

    // Stall for three cycles right after the first bit
    clear_stats();
    load_valid0 = 1'b1; din0 = 8'h81;
    tick();
    load_valid0 = 1'b0; shift_en0 = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    shift_en0 = 1'b1;
    for (int i = 0; i < 9; i++) tick();
    chk_int("stall_busy_cycles", bcnt, 11);
    chk_int("stall_last_pulses", lcnt, 1);

    // Reset mid-word, with a simultaneous load offered while reset is high
    clear_stats();
    load_valid0 = 1'b1; din0 = 8'h3C;
    tick();
    load_valid0 = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b1; load_valid0 = 1'b1; din0 = 8'hFF;
    tick();
    chk("rst_sout_zero", sout0, 1'b0);
    rst = 1'b0; load_valid0 = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk_int("rst_no_last", lcnt, 0);

    // Load offered mid-word is ignored
    clear_stats();
    load_valid0 = 1'b1; din0 = 8'h55;
    tick();
    load_valid0 = 1'b0;
    tick();
    tick();
    load_valid0 = 1'b1; din0 = 8'hAA;
    for (int i = 0; i < 3; i++) tick();
    load_valid0 = 1'b0; din0 = 8'h00;
    for (int i = 0; i < 4; i++) tick();
    chk_int("ignore_valid_cycles", vcnt, 8);
    chk_int("ignore_last_pulses", lcnt, 1);

    // LSB-first instance
    shift_en1 = 1'b1; load_valid1 = 1'b1; din1 = 8'h01;
    tick();
    load_valid1 = 1'b0; din1 = 8'h00;
    for (int i = 0; i < 9; i++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
